// File: rtl/uart_spi_pkg.sv
// Shared definitions for the UART/SPI byte bridge.
//   bridge_state_t : byte sequencing FSM states
//   DATA_W_DEFAULT : default byte width
package uart_spi_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPI_START = 3'd1,
    SPI_WAIT  = 3'd2,
    UART_SEND = 3'd3,
    UART_HOLD = 3'd4
  } bridge_state_t;

endpackage

// File: rtl/uart_spi_byte_bridge_fifo.sv
// byte_fifo: synchronous FIFO between the UART receiver and the SPI sequencer.
// Ports:
//   clk, reset          : system clock, async active-low reset
//   push_i, wdata_i     : write strobe and byte (caller never pushes into a full
//                         FIFO unless it pops in the same cycle)
//   pop_i               : read strobe (never asserted while empty)
//   rdata_o             : head byte, valid whenever empty_o is low
//   full_o, empty_o     : registered flags for the count after the current edge
//   count_o             : number of bytes held
module byte_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push_i,
  input  logic [DATA_W-1:0]               wdata_i,
  input  logic                            pop_i,
  output logic [DATA_W-1:0]               rdata_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(FIFO_DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_spi_byte_bridge.sv
// uart_spi_byte_bridge: buffers UART bytes, ships each as one SPI transaction
// and (with UART_SPI_BRIDGE_LOOPBACK_EN defined) returns the MISO byte to the
// UART transmitter.
// Ports:
//   clk, reset                    : system clock, async active-low reset
//   uart_rx_data/valid            : byte from UART receiver
//   uart_tx_data/start, _ready    : byte request to UART transmitter
//   spi_tx_data, spi_start        : SPI transaction request
//   spi_tx_done, spi_rx_data/valid: SPI completion and MISO byte
//   fifo_empty, fifo_full         : FIFO status
//   overflow                      : sticky, a byte arrived while full
// Build option: UART_SPI_BRIDGE_LOOPBACK_EN enables the UART return path.
//
// state     | meaning
// IDLE      | wait for a queued byte, pop it into spi_tx_data
// SPI_START | spi_start high for this cycle
// SPI_WAIT  | capture MISO byte, wait for spi_tx_done
// UART_SEND | wait for uart_tx_ready, then pulse uart_tx_start
// UART_HOLD | one cycle for the UART to drop ready
module uart_spi_byte_bridge
  import uart_spi_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] uart_rx_data,
  input  logic              uart_rx_valid,
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              uart_tx_start,
  input  logic              uart_tx_ready,
  output logic [DATA_W-1:0] spi_tx_data,
  output logic              spi_start,
  input  logic              spi_tx_done,
  input  logic [DATA_W-1:0] spi_rx_data,
  input  logic              spi_rx_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              overflow
);

  bridge_state_t                state_q, state_d;
  logic [DATA_W-1:0]            spi_tx_data_q, spi_tx_data_d;
  logic                         overflow_q, overflow_d;
  logic                         pop;
  logic                         push;
  logic [DATA_W-1:0]            fifo_head;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         unused_sink;

  assign pop  = (state_q == IDLE) && !fifo_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push = uart_rx_valid && (!fifo_full || pop);

  byte_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (uart_rx_data),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!fifo_empty) state_d = SPI_START;
      SPI_START: state_d = SPI_WAIT;
`ifdef UART_SPI_BRIDGE_LOOPBACK_EN
      SPI_WAIT:  if (spi_tx_done) state_d = UART_SEND;
      UART_SEND: if (uart_tx_ready) state_d = UART_HOLD;
      UART_HOLD: state_d = IDLE;
`else
      SPI_WAIT:  if (spi_tx_done) state_d = IDLE;
`endif
      default:   state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    spi_start     = 1'b0;
    uart_tx_start = 1'b0;
    case (state_q)
      SPI_START: spi_start = 1'b1;
`ifdef UART_SPI_BRIDGE_LOOPBACK_EN
      UART_SEND: uart_tx_start = uart_tx_ready;
`endif
      default: ;
    endcase
  end

  always_comb begin
    spi_tx_data_d = spi_tx_data_q;
    if (pop) spi_tx_data_d = fifo_head;
    overflow_d = overflow_q || (uart_rx_valid && fifo_full && !pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spi_tx_data_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      spi_tx_data_q <= spi_tx_data_d;
      overflow_q    <= overflow_d;
    end
  end

  assign spi_tx_data = spi_tx_data_q;
  assign overflow    = overflow_q;

`ifdef UART_SPI_BRIDGE_LOOPBACK_EN
  logic [DATA_W-1:0] rx_byte_q, rx_byte_d;

  always_comb begin
    rx_byte_d = rx_byte_q;
    if ((state_q == SPI_WAIT) && spi_rx_valid) rx_byte_d = spi_rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_byte_q <= '0;
    else        rx_byte_q <= rx_byte_d;
  end

  assign uart_tx_data = rx_byte_q;
  assign unused_sink  = ^fifo_count;
`else
  assign uart_tx_data = '0;
  assign unused_sink  = ^{fifo_count, spi_rx_data, spi_rx_valid, uart_tx_ready};
`endif

endmodule

// File: tb/tb_uart_spi_byte_bridge.sv
// Self-checking bench for uart_spi_byte_bridge. Follows the
// UART_SPI_BRIDGE_LOOPBACK_EN build option of the design.
module tb_uart_spi_byte_bridge;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] uart_rx_data;
  logic          uart_rx_valid;
  logic [DW-1:0] uart_tx_data;
  logic          uart_tx_start;
  logic          uart_tx_ready;
  logic [DW-1:0] spi_tx_data;
  logic          spi_start;
  logic          spi_tx_done;
  logic [DW-1:0] spi_rx_data;
  logic          spi_rx_valid;
  logic          fifo_empty;
  logic          fifo_full;
  logic          overflow;

  uart_spi_byte_bridge #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_ready (uart_tx_ready),
    .spi_tx_data   (spi_tx_data),
    .spi_start     (spi_start),
    .spi_tx_done   (spi_tx_done),
    .spi_rx_data   (spi_rx_data),
    .spi_rx_valid  (spi_rx_valid),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scoreboard: bytes the SPI side must see in order, bytes the UART must return.
  logic [DW-1:0] exp_spi[$];
  logic [DW-1:0] exp_uart[$];
  int start_cycles[$];
  int uart_cycles[$];
  int done_cycles[$];
  int n_starts = 0;
  int n_uart   = 0;
  logic full_watch = 1'b0;
  logic full_seen  = 1'b0;

  // SPI slave model controls
  logic          spi_busy   = 1'b0;
  logic          spi_stall  = 1'b0;
  int            spi_cnt    = 0;
  int            rv_off     = 0;
  logic [DW-1:0] spi_resp   = '0;
  logic          force_resp = 1'b0;
  logic [DW-1:0] forced     = '0;
  logic          rand_ready = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // SPI slave and UART readiness model, driven just after each edge.
  always @(posedge clk) begin
    #1;
    spi_tx_done  = 1'b0;
    spi_rx_valid = 1'b0;
    if (rand_ready) uart_tx_ready = ($urandom_range(3, 0) != 0);
    if (spi_busy && !spi_stall) begin
      if (spi_cnt == rv_off) begin
        spi_rx_valid = 1'b1;
        spi_rx_data  = spi_resp;
      end
      if (spi_cnt == 0) begin
        spi_tx_done = 1'b1;
        spi_busy    = 1'b0;
        done_cycles.push_back(cyc);
`ifdef UART_SPI_BRIDGE_LOOPBACK_EN
        exp_uart.push_back(spi_resp);
`endif
      end else begin
        spi_cnt--;
      end
    end else if (spi_start) begin
      spi_busy = 1'b1;
      spi_cnt  = $urandom_range(5, 1);
      rv_off   = $urandom_range(1, 0);
      spi_resp = force_resp ? forced : 8'($urandom);
    end
  end

  // Monitor: compares every presented transaction against the scoreboard.
  always @(negedge clk) begin
    if (full_watch && fifo_full) full_seen = 1'b1;
    if (spi_start) begin
      start_cycles.push_back(cyc);
      n_starts++;
      if (exp_spi.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spi_start_unexpected: got start with 0x%0h, expected none", spi_tx_data);
      end else begin
        chk("spi_tx_data", int'(spi_tx_data), int'(exp_spi.pop_front()));
      end
    end
    if (uart_tx_start) begin
      uart_cycles.push_back(cyc);
      n_uart++;
`ifdef UART_SPI_BRIDGE_LOOPBACK_EN
      if (exp_uart.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL uart_start_unexpected: got start with 0x%0h, expected none", uart_tx_data);
      end else begin
        chk("uart_tx_data", int'(uart_tx_data), int'(exp_uart.pop_front()));
      end
`else
      checks++;
      errors++;
      $display("FAIL uart_start_no_loopback: got uart_tx_start=1, expected 0");
`endif
    end
  end

  task automatic drain(input string name);
    int g = 0;
    while ((exp_spi.size() != 0 || exp_uart.size() != 0 || spi_busy || !fifo_empty) && g < 3000) begin
      tick();
      g++;
    end
    repeat (4) tick();
    checks++;
    if (g >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending bytes, expected 0", name, exp_spi.size() + exp_uart.size());
    end
  endtask

  task automatic clear_cycles();
    start_cycles.delete();
    uart_cycles.delete();
    done_cycles.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_spi_start"}, int'(spi_start), 0);
    chk({tag, "_spi_tx_data"}, int'(spi_tx_data), 0);
    chk({tag, "_uart_tx_start"}, int'(uart_tx_start), 0);
    chk({tag, "_uart_tx_data"}, int'(uart_tx_data), 0);
    chk({tag, "_fifo_empty"}, int'(fifo_empty), 1);
    chk({tag, "_fifo_full"}, int'(fifo_full), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask

  initial begin
    logic [DW-1:0] b;
    int push_cyc;
    int g;
    int n;
    int n0;
    int rise;

    rst_n         = 1'b0;
    uart_rx_data  = '0;
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b1;
    spi_tx_done   = 1'b0;
    spi_rx_data   = '0;
    spi_rx_valid  = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Single byte with a fixed MISO response
    clear_cycles();
    force_resp = 1'b1;
    forced     = 8'h3C;
    tick();
    uart_rx_data  = 8'hA5;
    uart_rx_valid = 1'b1;
    exp_spi.push_back(8'hA5);
    push_cyc = cyc;
    tick();
    uart_rx_valid = 1'b0;
    g = 0;
    while (start_cycles.size() == 0 && g < 100) begin tick(); g++; end
    if (start_cycles.size() == 0) chk("single_start_seen", 0, 1);
    else chk("single_start_latency", start_cycles[0] - push_cyc, 2);
    drain("single");
`ifdef UART_SPI_BRIDGE_LOOPBACK_EN
    if (uart_cycles.size() == 0 || done_cycles.size() == 0) chk("single_uart_seen", 0, 1);
    else chk("single_uart_latency", uart_cycles[0] - done_cycles[0], 1);

    // UART backpressure for 50 cycles after done
    clear_cycles();
    uart_tx_ready = 1'b0;
    tick();
    uart_rx_data  = 8'h77;
    uart_rx_valid = 1'b1;
    exp_spi.push_back(8'h77);
    tick();
    uart_rx_valid = 1'b0;
    g = 0;
    while (done_cycles.size() == 0 && g < 100) begin tick(); g++; end
    n0 = n_uart;
    repeat (50) tick();
    chk("backpressure_no_start", n_uart - n0, 0);
    uart_tx_ready = 1'b1;
    rise = cyc;
    repeat (5) tick();
    chk("backpressure_one_start", n_uart - n0, 1);
    if (uart_cycles.size() == 0) chk("backpressure_start_seen", 0, 1);
    else chk("backpressure_start_cycle", uart_cycles[0], rise);
    drain("backpressure");
`else
    chk("single_no_uart_start", n_uart, 0);
`endif
    force_resp = 1'b0;

    // Burst of four consecutive bytes
    clear_cycles();
    full_seen  = 1'b0;
    full_watch = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      uart_rx_data  = 8'(i);
      uart_rx_valid = 1'b1;
      exp_spi.push_back(8'(i));
    end
    tick();
    uart_rx_valid = 1'b0;
    drain("burst");
    full_watch = 1'b0;
    chk("burst_full_never", int'(full_seen), 0);
    chk("burst_overflow", int'(overflow), 0);
    chk("burst_start_count", start_cycles.size(), 4);
    if (start_cycles.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
`ifdef UART_SPI_BRIDGE_LOOPBACK_EN
        chk("b2b_uart_to_start", start_cycles[i] - uart_cycles[i-1], 3);
`else
        chk("b2b_done_to_start", start_cycles[i] - done_cycles[i-1], 2);
`endif
      end
    end

    // Random traffic, never more bytes pending than the FIFO can hold
    rand_ready = 1'b1;
    n = 0;
    g = 0;
    while (n < 40 && g < 5000) begin
      tick();
      g++;
      uart_rx_valid = 1'b0;
      if (exp_spi.size() < DEPTH && $urandom_range(2, 0) != 0) begin
        b = 8'($urandom);
        uart_rx_data  = b;
        uart_rx_valid = 1'b1;
        exp_spi.push_back(b);
        n++;
      end
    end
    tick();
    uart_rx_valid = 1'b0;
    drain("random");
    rand_ready    = 1'b0;
    uart_tx_ready = 1'b1;
    chk("random_overflow", int'(overflow), 0);

    // Overflow: SPI stalled, six consecutive bytes, sixth dropped
    spi_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      b = 8'h40 + 8'(i);
      uart_rx_data  = b;
      uart_rx_valid = 1'b1;
      if (i < 5) exp_spi.push_back(b);
    end
    tick();
    uart_rx_valid = 1'b0;
    chk("overflow_set", int'(overflow), 1);
    chk("overflow_full", int'(fifo_full), 1);
    spi_stall = 1'b0;
    drain("overflow");
    chk("overflow_sticky", int'(overflow), 1);
    chk("overflow_drained_empty", int'(fifo_empty), 1);

    // Reset during SPI_WAIT with two bytes queued
    clear_cycles();
    spi_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      b = 8'hC0 + 8'(i);
      uart_rx_data  = b;
      uart_rx_valid = 1'b1;
      exp_spi.push_back(b);
    end
    tick();
    uart_rx_valid = 1'b0;
    g = 0;
    while (!spi_busy && g < 50) begin tick(); g++; end
    chk("midreset_in_flight", int'(spi_busy), 1);
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_spi.delete();
    exp_uart.delete();
    spi_busy  = 1'b0;
    spi_stall = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    n0 = n_starts;
    repeat (20) tick();
    chk("midreset_no_start", n_starts - n0, 0);
    chk("midreset_empty", int'(fifo_empty), 1);

    chk("end_spi_queue", exp_spi.size(), 0);
    chk("end_uart_queue", exp_uart.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_spi_byte_bridge.md
# uart_spi_byte_bridge

Byte-level bridge between the UART receiver/transmitter and the SPI master of the UART/SPI loopback design. Each byte received by the UART is buffered in a small FIFO and shipped as one SPI transaction. The byte clocked back on MISO during that transaction is returned to the host through the UART transmitter. It sits between the UART and SPI blocks and owns all byte sequencing; the UART and SPI blocks keep only the serialization.

## Interface

Parameters:
- `DATA_W`, default 8: byte width on every data port.
- `FIFO_DEPTH`, default 4: UART-to-SPI FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `uart_rx_data`  in  DATA_W  byte from the UART receiver.
- `uart_rx_valid`  in  1  one-cycle strobe qualifying `uart_rx_data`.
- `uart_tx_data`  out  DATA_W  byte for the UART transmitter.
- `uart_tx_start`  out  1  one-cycle request to transmit `uart_tx_data`.
- `uart_tx_ready`  in  1  UART transmitter idle.
- `spi_tx_data`  out  DATA_W  byte to be shifted out on MOSI.
- `spi_start`  out  1  one-cycle request to start an SPI transaction.
- `spi_tx_done`  in  1  one-cycle strobe when the SPI transaction ends.
- `spi_rx_data`  in  DATA_W  byte captured from MISO.
- `spi_rx_valid`  in  1  one-cycle strobe qualifying `spi_rx_data`.
- `fifo_empty`  out  1  FIFO holds no bytes.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `overflow`  out  1  sticky flag: a received byte was dropped.

## Operation

- Reset values:
  - `uart_tx_data`, `spi_tx_data`: 0.
  - `uart_tx_start`, `spi_start`: 0.
  - `fifo_empty`: 1.
  - `fifo_full`, `overflow`: 0.
  - FSM in IDLE; FIFO pointers and count at 0.
- FIFO push: on `uart_rx_valid` when not full, write `uart_rx_data` at the write pointer.
- FIFO pop: on leaving IDLE.
- Pointers wrap modulo `FIFO_DEPTH`. The count is log2(`FIFO_DEPTH`)+1 bits.
- Push while full with a pop in the same cycle: pop frees a slot, so the push is accepted and the count is unchanged.
- Push while full with no pop: the byte is dropped, `overflow` sets and stays set until reset.
- Pop is never requested while the FIFO is empty.
- FSM states:
  - IDLE: if not `fifo_empty`, register the head byte into `spi_tx_data`, pop, go to SPI_START.
  - SPI_START: assert `spi_start` for exactly this cycle, go to SPI_WAIT.
  - SPI_WAIT: capture `spi_rx_data` on `spi_rx_valid`. On `spi_tx_done`, go to UART_SEND. If `spi_rx_valid` coincides with `spi_tx_done`, the capture still happens.
  - UART_SEND: while `uart_tx_ready` is 0, hold. When it is 1, drive `uart_tx_data` with the captured byte, assert `uart_tx_start` for one cycle, go to UART_HOLD.
  - UART_HOLD: wait one cycle, so the UART can drop ready, then go to IDLE.
- Only one SPI transaction is outstanding at a time. Bytes keep being accepted into the FIFO in every state.
- Reset mid-operation: everything returns to reset values immediately. The FIFO contents and any in-flight byte are discarded.

## Timing

- `uart_rx_valid` to `spi_start`, FIFO empty and FSM in IDLE: 2 cycles.
  - Cycle 1: push.
  - Cycle 2: IDLE pops and moves to SPI_START.
  - Cycle 3: `spi_start` is high.
- `spi_tx_done` to `uart_tx_start`, with `uart_tx_ready` = 1: 1 cycle.
- Back-to-back bytes: the next `spi_start` comes 3 cycles after `uart_tx_start` (UART_HOLD, IDLE, SPI_START).
- `fifo_empty` and `fifo_full` are registered and reflect the count after the current edge.

## Configuration

- `UART_SPI_BRIDGE_LOOPBACK_EN` defined: full behaviour above; SPI response bytes are returned over the UART.
- Not defined:
  - SPI_WAIT goes to IDLE on `spi_tx_done`; UART_SEND and UART_HOLD are removed.
  - `uart_tx_start` and `uart_tx_data` are tied to 0.
  - `spi_rx_data` is ignored.

## Structure

- Shared package `uart_spi_pkg`:
  - state enum `bridge_state_t` (IDLE, SPI_START, SPI_WAIT, UART_SEND, UART_HOLD);
  - `DATA_W_DEFAULT` = 8.
- One sub-module, `byte_fifo`: synchronous FIFO with push/pop/full/empty/count, parameterised by `DATA_W` and `FIFO_DEPTH`. The bridge holds the FSM and overflow logic.

## Test plan

- Single byte, loopback on: push 0xA5; the SPI model returns 0x3C → `spi_tx_data` = 0xA5 when `spi_start` pulses 2 cycles after the push; `uart_tx_start` pulses with `uart_tx_data` = 0x3C 1 cycle after `spi_tx_done`.
- Burst: push 0x01, 0x02, 0x03, 0x04 on consecutive cycles → SPI sees 0x01 to 0x04 in order; `fifo_full` never sets (depth 4, one pop occurs); `overflow` stays 0.
- Overflow: stall the SPI (no `spi_tx_done`), push 6 bytes → the first 5 are kept (1 in flight plus 4 in the FIFO), the 6th is dropped, `overflow` = 1 and remains 1 after the FIFO drains.
- UART backpressure: hold `uart_tx_ready` = 0 for 50 cycles after `spi_tx_done` → `uart_tx_start` stays 0, then pulses exactly once on the cycle ready rises.
- Reset mid-transaction: assert `reset` low during SPI_WAIT with 2 bytes queued → all outputs return to reset values asynchronously; after release, no `spi_start` occurs without new input.
- Loopback macro undefined: push 0x5A → `spi_start` with 0x5A; `uart_tx_start` never asserts; the next queued byte starts 2 cycles after `spi_tx_done`.
